// File: rtl/linebuf_pkg.sv
// linebuf_pkg: window geometry and pixel type shared by the window line
// buffer and the downstream inner-product stages.
//   WIN      - window edge length (9)
//   WIN_AREA - elements per window (81)
//   PIX_W    - pixel width in bits (7)
//   pixel_t  - one unsigned pixel
package linebuf_pkg;

    localparam int WIN      = 9;
    localparam int WIN_AREA = WIN * WIN;
    localparam int PIX_W    = 7;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/row_delay.sv
// row_delay: enable-gated shift delay of DEPTH pixels. One image row when
// DEPTH equals the image width. Contents are not reset; the window logic
// never exposes data older than the rows it has rewritten.
//   clk  - clock, rising edge
//   en   - shift enable (one accepted pixel)
//   din  - pixel entering the line
//   dout - pixel accepted DEPTH enables ago
module row_delay
    import linebuf_pkg::*;
#(
    parameter int DEPTH = 28
) (
    input  logic   clk,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);

    pixel_t mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int k = 1; k < DEPTH; k++) mem[k] <= mem[k-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_linebuffer.sv
// window_linebuffer: streaming 9x9 window generator. Pixels arrive in raster
// order, one per pix_valid cycle. Eight chained row delays supply the eight
// older rows of the current column; each accepted pixel shifts that 9-pixel
// column into the window register. win_valid pulses for one cycle after
// every accepted pixel whose (row,col) are both >= 8.
//   clk, rst     - clock (rising edge), async active-high reset
//   pix_in       - 7-bit pixel
//   pix_valid    - pix_in accepted this cycle
//   sof          - start of frame, qualified by pix_valid; pixel is (0,0)
//   xarray       - window, row-major, [0] oldest top-left, [80] newest pixel
//   win_valid    - xarray holds a new complete window
//   win_x, win_y - col/row of the window's bottom-right pixel
//                  (ports exist only with LINEBUF_COORD_EN defined)
module window_linebuffer
    import linebuf_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output pixel_t                   xarray [0:WIN_AREA-1],
    output logic                     win_valid
`ifdef LINEBUF_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // ---------------------------------------------------------------
    // Raster position of the pixel on the input this cycle. sof
    // overrides the running counters so the pixel lands on (0,0).
    // ---------------------------------------------------------------
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          qualify;

    assign cur_col = sof ? '0 : col;
    assign cur_row = sof ? '0 : row;
    assign qualify = pix_valid && (cur_row >= RW'(WIN-1)) && (cur_col >= CW'(WIN-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (cur_col == CW'(IMG_W-1)) begin
                col <= '0;
                row <= (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // ---------------------------------------------------------------
    // Row delay chain: tap[k] is the pixel k rows above pix_in.
    // ---------------------------------------------------------------
    pixel_t tap [0:WIN-1];

    assign tap[0] = pix_in;

    for (genvar g = 0; g < WIN-1; g++) begin : g_dl
        row_delay #(.DEPTH(IMG_W)) u_dl (
            .clk  (clk),
            .en   (pix_valid),
            .din  (tap[g]),
            .dout (tap[g+1])
        );
    end

    // ---------------------------------------------------------------
    // Window register: columns move left, the new column enters at
    // j=8 with the oldest row (tap[8]) at the top. A window that
    // straddles a row wrap still shifts but is never flagged.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WIN_AREA; k++) xarray[k] <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= qualify;
            if (pix_valid) begin
                for (int i = 0; i < WIN; i++) begin
                    for (int j = 0; j < WIN-1; j++)
                        xarray[i*WIN+j] <= xarray[i*WIN+j+1];
                    xarray[i*WIN+WIN-1] <= tap[WIN-1-i];
                end
            end
        end
    end

`ifdef LINEBUF_COORD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_x <= '0;
            win_y <= '0;
        end else if (qualify) begin
            win_x <= cur_col;
            win_y <= cur_row;
        end
    end
`else
    // No coordinate registers in this build.
`endif

endmodule

// File: tb/tb_window_linebuffer.sv
module tb_window_linebuffer;
    import linebuf_pkg::*;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int N     = IMG_W * IMG_H;

    logic   clk = 1'b0;
    logic   rst;
    logic [PIX_W-1:0] pix_in;
    logic   pix_valid;
    logic   sof;
    pixel_t xarray [0:WIN_AREA-1];
    logic   win_valid;
`ifdef LINEBUF_COORD_EN
    logic [$clog2(IMG_W)-1:0] win_x;
    logic [$clog2(IMG_H)-1:0] win_y;
`endif

    window_linebuffer #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .xarray    (xarray),
        .win_valid (win_valid)
`ifdef LINEBUF_COORD_EN
        ,
        .win_x     (win_x),
        .win_y     (win_y)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a frame image written in raster order; the expected
    // window is read straight out of it by (row,col).
    int img [0:IMG_H-1][0:IMG_W-1];
    int m_idx   = 0;
    bit exp_valid;
    bit last_q  = 0;
    int exp_win [0:WIN_AREA-1];
    int exp_x, exp_y;

    task automatic push(input bit v, input bit s, input int p);
        int r, c;
        pix_valid = v; sof = s; pix_in = p[PIX_W-1:0];
        @(posedge clk);
        exp_valid = 0;
        if (v) begin
            if (s) m_idx = 0;
            r = m_idx / IMG_W;
            c = m_idx % IMG_W;
            img[r][c] = p;
            if (r >= 8 && c >= 8) begin
                exp_valid = 1;
                for (int i = 0; i < 9; i++)
                    for (int j = 0; j < 9; j++)
                        exp_win[i*9+j] = img[r-8+i][c-8+j];
                exp_x = c; exp_y = r;
            end
            last_q = exp_valid;
            m_idx  = (m_idx + 1) % N;
        end
        #1;
        pix_valid = 0; sof = 0;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1; pix_valid = 0; sof = 0; pix_in = 0;
        #12;
        bad = -1;
        for (int k = 0; k < WIN_AREA; k++) if (xarray[k] !== 7'd0) bad = k;
        n_chk++;
        if (win_valid === 1'b0 && bad < 0) n_pass++;
        else $display("FAIL reset_state: win_valid=%b bad_idx=%0d, want win_valid=0 all xarray 0", win_valid, bad);
        rst = 0;
        @(posedge clk); #1;
        m_idx = 0; last_q = 0;
        for (int k = 0; k < 300; k++) begin
            push(1, k == 0, int'($urandom_range(0, 127)));
            n_chk++;
            if (win_valid === exp_valid) n_pass++;
            else $display("FAIL reset_pre_valid k=%0d: got %b want %b", k, win_valid, exp_valid);
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2 rst = 1;
        #1;
        bad = -1;
        for (int k = 0; k < WIN_AREA; k++) if (xarray[k] !== 7'd0) bad = k;
        n_chk++;
        if (win_valid === 1'b0 && bad < 0) n_pass++;
        else $display("FAIL reset_async: win_valid=%b bad_idx=%0d, want 0 and all zero", win_valid, bad);
`ifdef LINEBUF_COORD_EN
        n_chk++;
        if (win_x === '0 && win_y === '0) n_pass++;
        else $display("FAIL reset_coord: got %0d,%0d want 0,0", win_x, win_y);
`endif
        @(posedge clk); #1;
        rst = 0;
        m_idx = 0; last_q = 0;
        // Restarted stream without sof: first strobe at (8,8).
        for (int k = 0; k < 300; k++) begin
            push(1, 0, int'($urandom_range(0, 127)));
            n_chk++;
            if (win_valid === exp_valid && (win_valid !== 1'b1 || k >= 232)) n_pass++;
            else $display("FAIL reset_restart k=%0d: win_valid got %b want %b", k, win_valid, exp_valid);
            if (exp_valid) begin
                bad = -1;
                for (int q = 0; q < WIN_AREA; q++) if (xarray[q] !== pixel_t'(exp_win[q])) bad = q;
                n_chk++;
                if (bad < 0) n_pass++;
                else $display("FAIL reset_restart_win k=%0d idx=%0d: got %0d want %0d", k, bad, xarray[bad], exp_win[bad]);
            end
        end
    endtask

    task automatic test_full_frame;
        int bad, nstrobe, first;
        nstrobe = 0; first = -1;
        for (int k = 0; k < N; k++) begin
            push(1, k == 0, ((k / IMG_W) + (k % IMG_W)) % 128);
            n_chk++;
            if (win_valid === exp_valid) n_pass++;
            else $display("FAIL frame_valid k=%0d: got %b want %b", k, win_valid, exp_valid);
            if (win_valid === 1'b1) begin
                nstrobe++;
                if (first < 0) begin
                    first = k;
                    n_chk++;
                    if (xarray[0] === 7'd0 && xarray[8] === 7'd8 && xarray[72] === 7'd8 && xarray[80] === 7'd16) n_pass++;
                    else $display("FAIL frame_first_win: [0]=%0d [8]=%0d [72]=%0d [80]=%0d want 0 8 8 16",
                                  xarray[0], xarray[8], xarray[72], xarray[80]);
                end
            end
            if (exp_valid) begin
                bad = -1;
                for (int q = 0; q < WIN_AREA; q++) if (xarray[q] !== pixel_t'(exp_win[q])) bad = q;
                n_chk++;
                if (bad < 0) n_pass++;
                else $display("FAIL frame_win k=%0d idx=%0d: got %0d want %0d", k, bad, xarray[bad], exp_win[bad]);
`ifdef LINEBUF_COORD_EN
                n_chk++;
                if (win_x == exp_x && win_y == exp_y) n_pass++;
                else $display("FAIL frame_coord k=%0d: got %0d,%0d want %0d,%0d", k, win_x, win_y, exp_x, exp_y);
`endif
            end
        end
        n_chk++;
        if (first == 232) n_pass++;
        else $display("FAIL frame_first_idx: got %0d want 232", first);
        n_chk++;
        if (nstrobe == 400) n_pass++;
        else $display("FAIL frame_count: got %0d want 400", nstrobe);
        n_chk++;
        if (xarray[80] === 7'd54) n_pass++;
        else $display("FAIL frame_last_win: xarray[80]=%0d want 54", xarray[80]);
`ifdef LINEBUF_COORD_EN
        n_chk++;
        if (win_x == 27 && win_y == 27) n_pass++;
        else $display("FAIL frame_last_coord: got %0d,%0d want 27,27", win_x, win_y);
`endif
    endtask

    task automatic test_gaps;
        int bad, nstrobe;
        nstrobe = 0;
        for (int k = 0; k < N; k++) begin
            push(1, k == 0, ((k / IMG_W) + (k % IMG_W)) % 128);
            n_chk++;
            if (win_valid === exp_valid) n_pass++;
            else $display("FAIL gap_valid k=%0d: got %b want %b", k, win_valid, exp_valid);
            if (win_valid === 1'b1) nstrobe++;
            if (exp_valid) begin
                bad = -1;
                for (int q = 0; q < WIN_AREA; q++) if (xarray[q] !== pixel_t'(exp_win[q])) bad = q;
                n_chk++;
                if (bad < 0) n_pass++;
                else $display("FAIL gap_win k=%0d idx=%0d: got %0d want %0d", k, bad, xarray[bad], exp_win[bad]);
            end
            push(0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 127)));
            n_chk++;
            if (win_valid === 1'b0) n_pass++;
            else $display("FAIL gap_idle k=%0d: win_valid got %b want 0", k, win_valid);
            if (last_q) begin
                bad = -1;
                for (int q = 0; q < WIN_AREA; q++) if (xarray[q] !== pixel_t'(exp_win[q])) bad = q;
                n_chk++;
                if (bad < 0) n_pass++;
                else $display("FAIL gap_hold k=%0d idx=%0d: got %0d want %0d", k, bad, xarray[bad], exp_win[bad]);
            end
        end
        n_chk++;
        if (nstrobe == 400) n_pass++;
        else $display("FAIL gap_count: got %0d want 400", nstrobe);
    endtask

    // sof at the start, at pixel (12,5), and on the last pixel of a frame.
    task automatic test_sof;
        int acc, since, bad;
        bit seen, s, v;
        acc = 0; since = 0; seen = 0;
        while (acc < 1124 + 300) begin
            s = (acc == 0 || acc == 341 || acc == 1124);
            v = s ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (s) begin
                if (acc > 0) begin
                    n_chk++;
                    if (seen) n_pass++;
                    else $display("FAIL sof_no_strobe acc=%0d: got none want one", acc);
                end
                since = 0; seen = 0;
            end
            push(v, s, int'($urandom_range(0, 127)));
            n_chk++;
            if (win_valid === exp_valid) n_pass++;
            else $display("FAIL sof_valid acc=%0d: got %b want %b", acc, win_valid, exp_valid);
            if (exp_valid) begin
                bad = -1;
                for (int q = 0; q < WIN_AREA; q++) if (xarray[q] !== pixel_t'(exp_win[q])) bad = q;
                n_chk++;
                if (bad < 0) n_pass++;
                else $display("FAIL sof_win acc=%0d idx=%0d: got %0d want %0d", acc, bad, xarray[bad], exp_win[bad]);
            end
            if (v) begin
                if (win_valid === 1'b1 && !seen) begin
                    seen = 1;
                    n_chk++;
                    if (since == 232) n_pass++;
                    else $display("FAIL sof_first_strobe: at pixel %0d after sof, want 232", since);
                end
                since++;
                acc++;
            end
        end
        n_chk++;
        if (seen) n_pass++;
        else $display("FAIL sof_no_strobe_end: got none want one");
    endtask

    task automatic test_back_to_back;
        int bad, nstrobe;
        nstrobe = 0;
        for (int k = 0; k < 2 * N; k++) begin
            push(1, k == 0, int'($urandom_range(0, 127)));
            n_chk++;
            if (win_valid === exp_valid) n_pass++;
            else $display("FAIL b2b_valid k=%0d: got %b want %b", k, win_valid, exp_valid);
            if (win_valid === 1'b1) nstrobe++;
            if (exp_valid) begin
                bad = -1;
                for (int q = 0; q < WIN_AREA; q++) if (xarray[q] !== pixel_t'(exp_win[q])) bad = q;
                n_chk++;
                if (bad < 0) n_pass++;
                else $display("FAIL b2b_win k=%0d idx=%0d: got %0d want %0d", k, bad, xarray[bad], exp_win[bad]);
            end
        end
        n_chk++;
        if (nstrobe == 800) n_pass++;
        else $display("FAIL b2b_count: got %0d want 800", nstrobe);
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_gaps;
        test_sof;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/window_linebuffer.md
# window_linebuffer

Streaming 9x9 window generator that sits directly upstream of the per-digit inner-product stages. Accepts one 7-bit pixel per valid cycle in raster order, holds the last eight image rows in row delay lines, and presents a registered 81-element window `xarray[0:80]` with a one-cycle `win_valid` strobe for every fully populated window position. The window feeds all inner-product instances in parallel; no backpressure exists because those consumers are combinational.

## Interface
- `IMG_W`, 28, pixels per image row (≥ 9)
- `IMG_H`, 28, rows per frame (≥ 9)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pix_in`  in  7  pixel value, unsigned
- `pix_valid`  in  1  `pix_in` accepted this cycle
- `sof`  in  1  start of frame; qualified by `pix_valid`; the accompanying pixel is (row 0, col 0)
- `xarray`  out  7 x [0:80]  window, unpacked array, row-major
- `win_valid`  out  1  one-cycle strobe: `xarray` holds a new complete window
- `win_x`, `win_y`  out  $clog2(IMG_W), $clog2(IMG_H)  column/row of the window's bottom-right pixel (present only with `LINEBUF_COORD_EN`)

## Operation
- Column counter `col` and row counter `row` advance on each accepted pixel. `col` wraps at IMG_W-1 to 0 and increments `row`. `row` wraps at IMG_H-1 to 0, so back-to-back frames need no `sof`.
- `sof` with `pix_valid` forces the pixel to (0,0). Counters then continue from (0,1). A `sof` mid-frame abandons the current frame.
- Eight row delay lines of depth IMG_W are chained. Each accepted pixel shifts a new 9-pixel column (8 delayed rows plus `pix_in`) into the 9x9 window register. Nothing shifts when `pix_valid` is low.
- Window for bottom-right pixel (r,c): `xarray[i*9+j]` = pixel(r-8+i, c-8+j), for i,j in 0..8. Index 0 is top-left (oldest); index 80 is the newest pixel.
- A window is qualifying when the accepted pixel has `row` ≥ 8 and `col` ≥ 8. That gives (IMG_W-8)*(IMG_H-8) windows per frame (400 at defaults).
- Windows straddling a row wrap are never flagged valid. `xarray` contents during non-valid cycles are don't-care but stable.
- Pixel arithmetic: no arithmetic; values pass through unchanged at 7 bits.

## Timing
- Latency: `win_valid` is high in the cycle after the qualifying pixel is accepted, with `xarray` updated on the same edge.
- `xarray` holds until the next accepted pixel.
- Reset values: `xarray` all 0, `win_valid` 0, `win_x`/`win_y` 0, counters 0. Delay-line contents are not cleared.
  - Stale data is never exposed, because eight full rows are rewritten before the next valid window.
- `rst` asserted mid-frame: outputs go to reset values asynchronously. The first valid window after release is the window at (8,8) of the new stream.
- `pix_valid` gaps: no state change, and `win_valid` stays 0 during the gap.
- `sof` on the last pixel of a frame: `sof` wins, and the pixel becomes (0,0).

## Configuration
- `LINEBUF_COORD_EN` defined: `win_x`/`win_y` ports exist. They are registered alongside `xarray` and equal the (col,row) of the qualifying pixel.
- Not defined: those ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `linebuf_pkg`:
  - constants `WIN` = 9 and `WIN_AREA` = 81, `PIX_W` = 7
  - `typedef logic [PIX_W-1:0] pixel_t`
  - used by this block and by the inner-product stages
- Sub-module `row_delay`: IMG_W-deep, enable-gated shift delay of `pixel_t`, instantiated eight times in a chain.

## Test plan
- Reset: assert `rst` mid-stream → `win_valid`=0 and all `xarray`=0 in the same cycle; no strobe until pixel (8,8) of a restarted stream.
- Full frame, pixel=(r+c)%128, `pix_valid` continuous → first `win_valid` the cycle after pixel index 232. That first window has `xarray[0]`=0, `xarray[8]`=8, `xarray[72]`=8, `xarray[80]`=16.
- Count strobes over one 28x28 frame → exactly 400. Last window has `xarray[80]`=54 and, with `LINEBUF_COORD_EN`, `win_x`=27 and `win_y`=27.
- `pix_valid` toggling every other cycle on the same frame → identical window sequence; each strobe is one cycle after an accepted pixel.
- `sof` reasserted at pixel (12,5) → no strobe until 232 accepted pixels later; the next window is built only from new-frame pixels.
- Two frames back-to-back without a second `sof` → 800 strobes; the first window of frame 2 uses only frame-2 pixels.
